// File: rtl/soc_pkg.sv
// Shared definitions for the serial-loopback SoC: APB register map, sequencer ROM
// layout and default contents, and the APB master state encoding.
package soc_pkg;

  localparam int APB_AW  = 4;
  localparam int APB_DW  = 11;
  localparam int ROM_W   = 11;
  localparam int FRAME_W = 9;

  localparam logic [APB_AW-1:0] ADDR_TXDATA = 4'h0;
  localparam logic [APB_AW-1:0] ADDR_STATUS = 4'h4;
  localparam logic [APB_AW-1:0] ADDR_RXDATA = 4'h8;

  localparam int STATUS_TX_BUSY  = 0;
  localparam int STATUS_RX_VALID = 1;

  localparam int ROM_BREAK    = 8;
  localparam int ROM_BAD_STOP = 9;
  localparam int ROM_NO_WAIT  = 10;

  typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_t;

  function automatic logic [ROM_W-1:0] default_rom(input int unsigned idx);
    case (idx)
      0:       return 11'h055;
      1:       return 11'h001;
      2:       return 11'h0A3;
      3:       return 11'h0FF;
      4:       return 11'h23C;
      5:       return 11'h100;
      6:       return 11'h481;
      7:       return 11'h07E;
      default: return '0;
    endcase
  endfunction

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/apb_uart.sv
// APB slave UART: TXDATA/STATUS/RXDATA registers, a bit-serial transmitter with
// break/bad-stop injection, and a mid-bit sampling receiver with OE/BE/FE flags.
module apb_uart
  import soc_pkg::*;
#(
  parameter int BAUD_DIV = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [APB_AW-1:0]  paddr,
  input  logic [APB_DW-1:0]  pwdata,
  output logic [APB_DW-1:0]  prdata,
  output logic               pready,
  output logic               tx,
  input  logic               rx,
  output logic [FRAME_W-1:0] rx_frame,
  output logic               oe,
  output logic               be,
  output logic               fe
);

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA} rx_state_t;

  function automatic logic [10:0] build_frame(input logic [APB_DW-1:0] w);
    if (w[ROM_BREAK]) return '0;
    return {~w[ROM_BAD_STOP], even_parity(w[7:0]), w[7:0], 1'b0};
  endfunction

  logic             tx_wr, rx_rd;
  logic             tx_busy, rx_valid;
  logic [10:0]      tx_shift;
  logic [CNT_W-1:0] tx_baud, rx_baud;
  logic [3:0]       tx_bits, rx_bits;
  rx_state_t        rx_state;
  logic             rx_prev;
  logic [9:0]       rx_shift;
  logic             vld_p1;
  logic             unused_bits;

  assign unused_bits = pwdata[ROM_NO_WAIT];
  assign pready = 1'b1;
  assign tx_wr  = psel & penable & pwrite & (paddr == ADDR_TXDATA);
  assign rx_rd  = psel & penable & ~pwrite & (paddr == ADDR_RXDATA);

  always_comb begin
    prdata = '0;
    case (paddr)
      ADDR_STATUS: prdata[1:0] = {rx_valid, tx_busy};
      ADDR_RXDATA: prdata[FRAME_W-1:0] = rx_frame;
      default:     prdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_busy  <= 1'b0;
      tx       <= 1'b1;
      tx_shift <= '1;
      tx_baud  <= '0;
      tx_bits  <= '0;
    end else if (tx_wr && !tx_busy) begin
      tx_busy  <= 1'b1;
      tx_shift <= build_frame(pwdata);
      tx       <= 1'b0;
      tx_baud  <= '0;
      tx_bits  <= '0;
    end else if (tx_busy) begin
      if (tx_baud == BIT_LAST) begin
        tx_baud <= '0;
        if (tx_bits == 4'd10) begin
          tx_busy <= 1'b0;
          tx      <= 1'b1;
        end else begin
          tx_bits  <= tx_bits + 1'b1;
          tx_shift <= {1'b1, tx_shift[10:1]};
          tx       <= tx_shift[1];
        end
      end else begin
        tx_baud <= tx_baud + 1'b1;
      end
    end
  end

  // p0: edge detect, start confirmation and mid-bit sampling
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_prev  <= 1'b1;
      rx_baud  <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      vld_p1   <= 1'b0;
    end else begin
      rx_prev <= rx;
      vld_p1  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx) begin
            rx_state <= RX_START;
            rx_baud  <= '0;
          end
        end
        RX_START: begin
          if (rx_baud == HALF_LAST) begin
            rx_baud  <= '0;
            rx_bits  <= '0;
            rx_state <= rx ? RX_IDLE : RX_DATA;
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_baud == BIT_LAST) begin
            rx_baud  <= '0;
            rx_shift <= {rx, rx_shift[9:1]};
            if (rx_bits == 4'd9) begin
              rx_state <= RX_IDLE;
              vld_p1   <= 1'b1;
            end else begin
              rx_bits <= rx_bits + 1'b1;
            end
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // p1: frame completion; a coincident RXDATA read loses to the new frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_frame <= '0;
      oe       <= 1'b0;
      be       <= 1'b0;
      fe       <= 1'b0;
      rx_valid <= 1'b0;
    end else if (vld_p1) begin
      rx_frame <= rx_shift[8:0];
      be       <= (rx_shift == '0);
      fe       <= !rx_shift[9] && (rx_shift != '0);
      oe       <= rx_valid && !rx_rd;
      rx_valid <= 1'b1;
    end else if (rx_rd) begin
      rx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/soc_top.sv
// Loopback SoC top: ROM-driven sequencer acting as APB master to apb_uart, whose
// TX line is wired straight back into its RX.
module soc_top
  import soc_pkg::*;
#(
  parameter int BAUD_DIV  = 50,
  parameter int ROM_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic [FRAME_W-1:0] data_out,
  output logic               OE,
  output logic               BE,
  output logic               FE
);

  localparam int IDX_W = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROM_DEPTH - 1);

  typedef enum logic [2:0] {OP_POLL_TX, OP_WRITE, OP_POLL_RX, OP_READ, OP_DONE} seq_op_t;

  apb_state_t        apb_state, apb_state_nxt;
  seq_op_t           op, op_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [ROM_W-1:0]  entry;
  logic              advance;
  logic              psel, penable, pwrite, pready;
  logic [APB_AW-1:0] paddr;
  logic [APB_DW-1:0] pwdata, prdata;
  logic              line;
  logic              unused_prdata;

  assign entry         = default_rom(32'(idx));
  assign unused_prdata = ^prdata[APB_DW-1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      apb_state <= APB_IDLE;
      op        <= OP_POLL_TX;
      idx       <= '0;
    end else begin
      apb_state <= apb_state_nxt;
      op        <= op_nxt;
      idx       <= idx_nxt;
    end
  end

  // The RX poll also waits for TX idle so the entry's own frame has landed before the read
  always_comb begin
    apb_state_nxt = apb_state;
    op_nxt        = op;
    idx_nxt       = idx;
    advance       = 1'b0;
    psel          = 1'b0;
    penable       = 1'b0;
    pwrite        = (op == OP_WRITE);
    paddr         = ADDR_STATUS;
    pwdata        = '0;
    case (op)
      OP_WRITE: begin
        paddr  = ADDR_TXDATA;
        pwdata = entry;
      end
      OP_READ: paddr = ADDR_RXDATA;
      default: ;
    endcase
    case (apb_state)
      APB_IDLE: if (op != OP_DONE) apb_state_nxt = APB_SETUP;
      APB_SETUP: begin
        psel          = 1'b1;
        apb_state_nxt = APB_ACCESS;
      end
      APB_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          case (op)
            OP_POLL_TX: if (!prdata[STATUS_TX_BUSY]) op_nxt = OP_WRITE;
            OP_WRITE:   if (entry[ROM_NO_WAIT]) advance = 1'b1; else op_nxt = OP_POLL_RX;
            OP_POLL_RX: if (prdata[STATUS_RX_VALID] && !prdata[STATUS_TX_BUSY]) op_nxt = OP_READ;
            OP_READ:    advance = 1'b1;
            default:    ;
          endcase
          if (advance) begin
            if (idx == LAST_IDX) begin
              op_nxt = OP_DONE;
            end else begin
              idx_nxt = idx + 1'b1;
              op_nxt  = OP_POLL_TX;
            end
          end
          apb_state_nxt = (op_nxt == OP_DONE) ? APB_IDLE : APB_SETUP;
        end
      end
      default: apb_state_nxt = APB_IDLE;
    endcase
  end

  apb_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk      (clk),
    .rst      (rst),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .tx       (line),
    .rx       (line),
    .rx_frame (data_out),
    .oe       (OE),
    .be       (BE),
    .fe       (FE)
  );

endmodule

// File: tb/tb_soc_top.sv
// Self-checking bench for soc_top: observed frames and flags against a frame-level
// model of the default ROM, with randomized observation points and reset timing.
module tb_soc_top;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] data_out;
  logic       OE, BE, FE;

  int total = 0;
  int bad   = 0;
  int elapsed;

  logic [10:0] rom [8] = '{11'h055, 11'h001, 11'h0A3, 11'h0FF,
                           11'h23C, 11'h100, 11'h481, 11'h07E};
  logic [8:0]  exp_data [8];
  logic [2:0]  exp_flags [8];
  logic [11:0] last_obs;

  soc_top #(.BAUD_DIV(50), .ROM_DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_out (data_out),
    .OE       (OE),
    .BE       (BE),
    .FE       (FE)
  );

  always #10 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
    $fatal(1);
  end

  // Frame-level model: each entry yields one frame; it stays unread only when no_wait is set.
  task automatic build_model();
    bit         unread;
    logic [7:0] b;
    bit         brk;
    unread = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b   = rom[i][7:0];
      brk = rom[i][8];
      exp_data[i]  = brk ? 9'h000 : {^b, b};
      exp_flags[i] = {unread, brk, rom[i][9] && !brk};
      unread       = rom[i][10];
    end
  endtask

  task automatic wait_change(input int budget, output bit seen, output int cycles);
    logic [11:0] cur;
    seen   = 1'b0;
    cycles = 0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      cur = {data_out, OE, BE, FE};
      if (cur !== last_obs) begin
        last_obs = cur;
        seen     = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0;
    #15;
    total++;
    if (data_out !== 9'h000) begin
      bad++; $display("FAIL reset_data: got %h want %h", data_out, 9'h000);
    end
    total++;
    if ({OE, BE, FE} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b want %b", {OE, BE, FE}, 3'b000);
    end
    #5 rst = 1'b1;
    n = $urandom_range(1, 450);
    repeat (n) @(negedge clk);
    total++;
    if (data_out !== 9'h000) begin
      bad++; $display("FAIL pre_frame_data: got %h want %h", data_out, 9'h000);
    end
    total++;
    if ({OE, BE, FE} !== 3'b000) begin
      bad++; $display("FAIL pre_frame_flags: got %b want %b", {OE, BE, FE}, 3'b000);
    end
    last_obs = 12'h000;
    elapsed  = n;
  endtask

  task automatic test_first_frame();
    bit seen;
    int c;
    wait_change(600 - elapsed, seen, c);
    total++;
    if (!seen) begin
      bad++; $display("FAIL first_frame_latency: no frame after %0d cycles, want <= 600", elapsed + c);
    end
    total++;
    if (data_out !== exp_data[0]) begin
      bad++; $display("FAIL frame0_data: got %h want %h", data_out, exp_data[0]);
    end
    total++;
    if ({OE, BE, FE} !== exp_flags[0]) begin
      bad++; $display("FAIL frame0_flags: got %b want %b", {OE, BE, FE}, exp_flags[0]);
    end
  endtask

  task automatic test_sequence();
    bit seen;
    int c;
    for (int i = 1; i < 8; i++) begin
      wait_change(2000, seen, c);
      total++;
      if (!seen) begin
        bad++; $display("FAIL frame%0d_timeout: no frame after %0d cycles, want one", i, c);
      end
      total++;
      if (data_out !== exp_data[i]) begin
        bad++; $display("FAIL frame%0d_data: got %h want %h", i, data_out, exp_data[i]);
      end
      total++;
      if ({OE, BE, FE} !== exp_flags[i]) begin
        bad++; $display("FAIL frame%0d_flags (OE,BE,FE): got %b want %b", i, {OE, BE, FE}, exp_flags[i]);
      end
    end
  endtask

  task automatic test_idle();
    bit seen;
    int c;
    wait_change(3000, seen, c);
    total++;
    if (seen) begin
      bad++; $display("FAIL idle_quiet: outputs changed to %h after %0d cycles, want no change", last_obs, c);
    end
  endtask

  task automatic test_mid_reset();
    bit seen;
    int c;
    int n;
    rst = 1'b0;
    #1;
    total++;
    if ({data_out, OE, BE, FE} !== 12'h000) begin
      bad++; $display("FAIL async_reset: got %h want %h", {data_out, OE, BE, FE}, 12'h000);
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
    rst = 1'b1;
    last_obs = 12'h000;
    wait_change(600, seen, c);
    total++;
    if (!seen || data_out !== exp_data[0] || {OE, BE, FE} !== exp_flags[0]) begin
      bad++; $display("FAIL restart1_frame0: got %h/%b want %h/%b", data_out, {OE, BE, FE}, exp_data[0], exp_flags[0]);
    end
    n = $urandom_range(100, 450);
    repeat (n) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({data_out, OE, BE, FE} !== 12'h000) begin
      bad++; $display("FAIL midframe_reset: got %h want %h", {data_out, OE, BE, FE}, 12'h000);
    end
    @(negedge clk);
    rst = 1'b1;
    last_obs = 12'h000;
    for (int i = 0; i < 2; i++) begin
      wait_change(2000, seen, c);
      total++;
      if (!seen) begin
        bad++; $display("FAIL restart2_frame%0d_timeout: no frame after %0d cycles, want one", i, c);
      end
      total++;
      if (data_out !== exp_data[i] || {OE, BE, FE} !== exp_flags[i]) begin
        bad++; $display("FAIL restart2_frame%0d: got %h/%b want %h/%b", i, data_out, {OE, BE, FE}, exp_data[i], exp_flags[i]);
      end
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_first_frame();
    test_sequence();
    test_idle();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
